mcu_spi_slave: RTL

SPI slave front end for the MCU control link. It recovers the MCU's mode-0 SPI stream in the system clock domain and presents each received byte to the system-control block as a one-cycle strobe, with a frame-start flag on the first byte after chip select. It serializes the control block's response byte back to the MCU on MISO. The block sits directly upstream of the system-control block and produces its `data_in_strobe`, `data_in_start` and `data_in` inputs.

---
 rtl/mcu_spi_slave.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mcu_spi_slave.sv
// Purpose: SPI mode-0 slave for the MCU control link; recovers MOSI bytes in clk domain, shifts tx_data out on MISO.
// Latency: byte_strobe ~3 clk after the 8th SCK rising pin edge; spi_miso ~4 clk after an SCK falling pin edge.
// Backpressure: none; the MCU paces the link and the control block must accept every byte_strobe.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   spi_ss_n/sck/mosi   raw SPI pins from the MCU (asynchronous to clk)
//   spi_miso            registered MISO, 0 outside an armed frame
//   byte_strobe/start   one-cycle byte valid, start flags first byte of frame
//   byte_data           last received byte, held between strobes
//   tx_data             response byte, sampled one cycle after byte_strobe
//   frame_active        chip select synchronized low and frame armed
module mcu_spi_slave #(
   parameter int SYNC_STAGES = 2   // 2 or 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_ss_n,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       byte_strobe,
   output logic       byte_start,
   output logic [7:0] byte_data,
   input  logic [7:0] tx_data,
   output logic       frame_active
);

   typedef enum logic [1:0] {
      ST_UNARMED,   // SS not yet seen high since reset
      ST_ARMED,     // idle, waiting for SS falling edge
      ST_ACTIVE     // frame in progress
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] ss_pipe, sck_pipe, mosi_pipe;
   logic       ss_d, sck_d;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;   // first seven bits; the eighth comes straight from mosi_s
   logic [7:0] tx_shift;
   logic       first;
   logic       strobe_d;

   logic ss_s, sck_s, mosi_s;
   logic ss_rise, ss_fall, sck_rise, sck_fall;
   logic start_frame, end_frame, in_frame;

   // Synchronizers reset to 0 so that SS reads as "low" until the pin
   // has really been seen high; this keeps a frame that straddles reset
   // release from ever arming.
   always_ff @(posedge clk) begin
      if (reset) begin
         ss_pipe   <= '0;
         sck_pipe  <= '0;
         mosi_pipe <= '0;
         ss_d      <= 1'b0;
         sck_d     <= 1'b0;
      end else begin
         ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], spi_ss_n};
         sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
         ss_d      <= ss_s;
         sck_d     <= sck_s;
      end
   end

   assign ss_s     = ss_pipe[SYNC_STAGES-1];
   assign sck_s    = sck_pipe[SYNC_STAGES-1];
   assign mosi_s   = mosi_pipe[SYNC_STAGES-1];

   assign ss_rise  =  ss_s  & ~ss_d;
   assign ss_fall  = ~ss_s  &  ss_d;
   assign sck_rise =  sck_s & ~sck_d;
   assign sck_fall = ~sck_s &  sck_d;

   // SS edges take priority over SCK: a start ignores a coincident SCK
   // edge (state is still ARMED), and an end kills a coincident wrap.
   assign start_frame = (state == ST_ARMED)  & ss_fall;
   assign end_frame   = (state == ST_ACTIVE) & ss_rise;
   assign in_frame    = (state == ST_ACTIVE) & ~ss_rise;

   assign frame_active = (state == ST_ACTIVE);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_UNARMED;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_UNARMED: if (ss_s)        state_nxt = ST_ARMED;
         ST_ARMED:   if (start_frame) state_nxt = ST_ACTIVE;
         ST_ACTIVE:  if (end_frame)   state_nxt = ST_ARMED;
         default:                     state_nxt = ST_UNARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         spi_miso    <= 1'b0;
         byte_strobe <= 1'b0;
         byte_start  <= 1'b0;
         byte_data   <= 8'h00;
         bit_cnt     <= 3'd0;
         rx_shift    <= 7'd0;
         tx_shift    <= 8'h00;
         first       <= 1'b0;
         strobe_d    <= 1'b0;
      end else begin
         byte_strobe <= 1'b0;
         byte_start  <= 1'b0;
         strobe_d    <= byte_strobe;
         spi_miso    <= frame_active & tx_shift[7];

         if (start_frame) begin
            first    <= 1'b1;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
         end else if (end_frame) begin
            // partial byte dropped, byte_data untouched
            bit_cnt  <= 3'd0;
         end else if (in_frame) begin
            if (sck_rise) begin
               rx_shift <= {rx_shift[5:0], mosi_s};
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_data   <= {rx_shift, mosi_s};
                  byte_strobe <= 1'b1;
                  byte_start  <= first;
                  first       <= 1'b0;
               end
            end
            // Reload lands two edges after the strobe so the control block
            // has a full cycle to register its answer; the MCU guarantees
            // the 8th falling edge (counter 0, no shift) comes later.
            if (strobe_d) begin
               tx_shift <= tx_data;
            end else if (sck_fall && bit_cnt != 3'd0) begin
               tx_shift <= {tx_shift[6:0], 1'b0};
            end
         end
      end
   end

endmodule
